// File: rtl/layer4_pkg.sv
// layer4_pkg: shared sizes and enums for the layer4 buffer controller.
// Optional forwarding path is enabled by L4_BYPASS_FWD_EN in layer4_buf_ctrl.
package layer4_pkg;

    localparam int L4_DEPTH = 144;
    localparam int L4_AW    = 8;
    localparam int L4_DW    = 128;

    typedef enum logic [1:0] {
        REQ_WR,
        REQ_CR,
        REQ_DM
    } req_e;

    typedef enum logic [1:0] {
        PORT_NONE,
        PORT_A,
        PORT_B,
        PORT_FWD
    } port_e;

endpackage

// File: rtl/layer4_scoreboard.sv
// layer4_scoreboard: per-word written flags and distinct-write counter.
// A synchronous clear starts a new layer.
module layer4_scoreboard
    import layer4_pkg::*;
#(
    parameter int DEPTH = L4_DEPTH,
    parameter int AW    = L4_AW
) (
    input  logic          CK,
    input  logic          RSTn,
    input  logic          clear,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic [AW-1:0] look_addr,
    output logic          look_hit,
    output logic [AW-1:0] fill_cnt,
    output logic          all_written
);

    localparam logic [AW-1:0] LIM = AW'(DEPTH);

    logic [DEPTH-1:0] written;
    logic             set_new;

    // Only the first write to a word advances the counter
    assign set_new     = set_en && (set_addr < LIM) && !written[set_addr];
    assign look_hit    = (look_addr < LIM) && written[look_addr];
    assign all_written = (fill_cnt == LIM);

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            written  <= '0;
            fill_cnt <= '0;
        end else if (clear) begin
            written  <= '0;
            fill_cnt <= '0;
        end else if (set_new) begin
            written[set_addr] <= 1'b1;
            fill_cnt          <= fill_cnt + AW'(1);
        end
    end

endmodule

// File: rtl/layer4_buf_ctrl.sv
// layer4_buf_ctrl: arbitrates WR/CR/DM onto the dual-port layer4 SRAM.
// Define L4_BYPASS_FWD_EN to forward same-cycle write data to compute reads.
module layer4_buf_ctrl
    import layer4_pkg::*;
#(
    parameter int DEPTH = L4_DEPTH,
    parameter int AW    = L4_AW,
    parameter int DW    = L4_DW
) (
    input  logic          CK,
    input  logic          RSTn,
    input  logic          clear,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          cr_valid,
    output logic          cr_ready,
    input  logic [AW-1:0] cr_addr,
    output logic          cr_rvalid,
    output logic [DW-1:0] cr_rdata,
    input  logic          dm_valid,
    output logic          dm_ready,
    input  logic [AW-1:0] dm_addr,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic [AW-1:0] fill_cnt,
    output logic          all_written,
    output logic          err_addr,
    output logic          OEA,
    output logic          OEB,
    output logic          WEAN,
    output logic          WEBN,
    output logic [AW-1:0] A,
    output logic [AW-1:0] B,
    output logic [DW-1:0] DIA,
    output logic [DW-1:0] DIB,
    input  logic [DW-1:0] DOA,
    input  logic [DW-1:0] DOB
);

    localparam logic [AW-1:0] LIM = AW'(DEPTH);

    logic  wr_ok, cr_ok, dm_ok;
    logic  wr_go, cr_want, cr_fwd, cr_hit;
    logic  dm_want, dm_a_ok, dm_b_ok;
    logic  cr_b, dm_b, dm_a;
    req_e  rr_q, rr_d;
    port_e cr_tag, dm_tag, cr_tag_d, dm_tag_d;

    assign wr_ok = (wr_addr < LIM);
    assign cr_ok = (cr_addr < LIM);
    assign dm_ok = (dm_addr < LIM);

    assign err_addr = RSTn && ((wr_valid && !wr_ok) ||
                               (cr_valid && !cr_ok) ||
                               (dm_valid && !dm_ok));

    layer4_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sb (
        .CK          (CK),
        .RSTn        (RSTn),
        .clear       (clear),
        .set_en      (wr_go),
        .set_addr    (wr_addr),
        .look_addr   (cr_addr),
        .look_hit    (cr_hit),
        .fill_cnt    (fill_cnt),
        .all_written (all_written)
    );

    // Grant decision: WR owns A; CR only ever uses B; DM takes whichever is free
    always_comb begin
        wr_go   = 1'b0;
        cr_want = 1'b0;
        cr_fwd  = 1'b0;
        dm_want = 1'b0;
        dm_a_ok = 1'b0;
        dm_b_ok = 1'b0;
        cr_b    = 1'b0;
        dm_b    = 1'b0;
        dm_a    = 1'b0;
        if (RSTn && !clear) begin
            wr_go   = wr_valid && wr_ok;
            dm_want = dm_valid && dm_ok;
            cr_want = cr_valid && cr_ok && cr_hit &&
                      !(wr_go && wr_addr == cr_addr);
`ifdef L4_BYPASS_FWD_EN
            cr_fwd  = cr_valid && cr_ok && wr_go &&
                      (wr_addr == cr_addr);
`endif
            dm_b_ok = dm_want && !(wr_go && wr_addr == dm_addr);
            dm_a_ok = dm_want && !wr_go;
            if (cr_want && dm_a_ok && cr_addr != dm_addr) begin
                cr_b = 1'b1;
                dm_a = 1'b1;
            end else if (cr_want && dm_b_ok) begin
                if (rr_q == REQ_CR) cr_b = 1'b1;
                else                dm_b = 1'b1;
            end else begin
                cr_b = cr_want;
                dm_b = dm_b_ok;
            end
        end
    end

    always_comb begin
        rr_d     = rr_q;
        cr_tag_d = PORT_NONE;
        dm_tag_d = PORT_NONE;
        if (cr_b)      rr_d = REQ_DM;
        else if (dm_b) rr_d = REQ_CR;
        if (cr_b)        cr_tag_d = PORT_B;
        else if (cr_fwd) cr_tag_d = PORT_FWD;
        if (dm_b)      dm_tag_d = PORT_B;
        else if (dm_a) dm_tag_d = PORT_A;
    end

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            rr_q   <= REQ_CR;
            cr_tag <= PORT_NONE;
            dm_tag <= PORT_NONE;
        end else begin
            rr_q   <= rr_d;
            cr_tag <= cr_tag_d;
            dm_tag <= dm_tag_d;
        end
    end

`ifdef L4_BYPASS_FWD_EN
    logic [DW-1:0] fwd_q;

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn)       fwd_q <= '0;
        else if (cr_fwd) fwd_q <= wr_data;
    end
`endif

    // Idle port is parked on an address that differs from the busy port
    always_comb begin
        wr_ready = 1'b0;
        cr_ready = 1'b0;
        dm_ready = 1'b0;
        OEA      = 1'b0;
        OEB      = 1'b0;
        WEAN     = 1'b1;
        WEBN     = 1'b1;
        A        = '0;
        B        = '0;
        DIA      = '0;
        DIB      = '0;
        if (wr_go) begin
            wr_ready = 1'b1;
            WEAN     = 1'b0;
            A        = wr_addr;
            DIA      = wr_data;
        end else if (dm_a) begin
            dm_ready = 1'b1;
            OEA      = 1'b1;
            A        = dm_addr;
        end
        if (cr_b) begin
            cr_ready = 1'b1;
            OEB      = 1'b1;
            B        = cr_addr;
        end else if (dm_b) begin
            dm_ready = 1'b1;
            OEB      = 1'b1;
            B        = dm_addr;
        end
        if (cr_fwd) cr_ready = 1'b1;
        if (!(wr_go || dm_a) && OEB)
            A = (B == '0) ? AW'(1) : '0;
        if (!OEB && (wr_go || dm_a))
            B = (A == '0) ? AW'(1) : '0;
    end

    assign cr_rvalid = (cr_tag != PORT_NONE);
    assign dm_rvalid = (dm_tag != PORT_NONE);

    always_comb begin
        case (cr_tag)
            PORT_A:   cr_rdata = DOA;
            PORT_B:   cr_rdata = DOB;
`ifdef L4_BYPASS_FWD_EN
            PORT_FWD: cr_rdata = fwd_q;
`endif
            default:  cr_rdata = '0;
        endcase
    end

    always_comb begin
        case (dm_tag)
            PORT_A:  dm_rdata = DOA;
            PORT_B:  dm_rdata = DOB;
            default: dm_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_layer4_buf_ctrl.sv
// tb_layer4_buf_ctrl: vector table plus read-return scoreboard
// around a behavioural model of the dual-port SRAM.
module tb_layer4_buf_ctrl;
    import layer4_pkg::*;

    localparam int AW    = L4_AW;
    localparam int DW    = L4_DW;
    localparam int DEPTH = L4_DEPTH;
    localparam logic [AW-1:0] LIM = 8'd144;
`ifdef L4_BYPASS_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          CK, RSTn, clear;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cr_valid, cr_ready, cr_rvalid;
    logic [AW-1:0] cr_addr;
    logic [DW-1:0] cr_rdata;
    logic          dm_valid, dm_ready, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_rdata;
    logic [AW-1:0] fill_cnt;
    logic          all_written, err_addr;
    logic          OEA, OEB, WEAN, WEBN;
    logic [AW-1:0] A, B;
    logic [DW-1:0] DIA, DIB, DOA, DOB;

    int n_vec = 0;
    int n_err = 0;

    layer4_buf_ctrl dut (
        .CK(CK), .RSTn(RSTn), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_addr(cr_addr),
        .cr_rvalid(cr_rvalid), .cr_rdata(cr_rdata),
        .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_addr(dm_addr),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .fill_cnt(fill_cnt), .all_written(all_written),
        .err_addr(err_addr),
        .OEA(OEA), .OEB(OEB), .WEAN(WEAN), .WEBN(WEBN),
        .A(A), .B(B), .DIA(DIA), .DIB(DIB), .DOA(DOA), .DOB(DOB)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    always @(posedge CK) begin
        if (!WEAN && A < LIM) mem[A] <= DIA;
        if (OEA && A < LIM)   DOA <= mem[A];
        if (OEB && B < LIM)   DOB <= mem[B];
    end

    logic [DW-1:0] cr_q[$];
    logic [DW-1:0] dm_q[$];
    logic [DW-1:0] exp_d;
    bit            cr_pend, dm_pend;

    always @(negedge CK) begin
        if (!RSTn) begin
            cr_q.delete();
            dm_q.delete();
            cr_pend = 1'b0;
            dm_pend = 1'b0;
        end else begin
            if (cr_pend || cr_rvalid) begin
                n_vec++;
                if (cr_pend && cr_rvalid && cr_q.size() > 0) begin
                    exp_d = cr_q.pop_front();
                    if (cr_rdata !== exp_d) begin
                        n_err++;
                        $display("FAIL cr_rdata: got %h want %h", cr_rdata, exp_d);
                    end
                end else begin
                    n_err++;
                    $display("FAIL cr_rvalid: got %0b want %0b", cr_rvalid, cr_pend);
                    cr_q.delete();
                end
            end
            if (dm_pend || dm_rvalid) begin
                n_vec++;
                if (dm_pend && dm_rvalid && dm_q.size() > 0) begin
                    exp_d = dm_q.pop_front();
                    if (dm_rdata !== exp_d) begin
                        n_err++;
                        $display("FAIL dm_rdata: got %h want %h", dm_rdata, exp_d);
                    end
                end else begin
                    n_err++;
                    $display("FAIL dm_rvalid: got %0b want %0b", dm_rvalid, dm_pend);
                    dm_q.delete();
                end
            end
            cr_pend = 1'b0;
            dm_pend = 1'b0;
            if (cr_valid && cr_ready) begin
                cr_q.push_back((wr_valid && wr_ready && wr_addr == cr_addr) ?
                               wr_data : ref_mem[cr_addr]);
                cr_pend = 1'b1;
            end
            if (dm_valid && dm_ready) begin
                dm_q.push_back(ref_mem[dm_addr]);
                dm_pend = 1'b1;
            end
            if (wr_valid && wr_ready) ref_mem[wr_addr] = wr_data;
            if (OEA || OEB || !WEAN) begin
                n_vec++;
                if (A == B) begin
                    n_err++;
                    $display("FAIL port_collision: A=%0d B=%0d must differ", A, B);
                end
            end
        end
    end

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        logic          cv;
        logic [AW-1:0] ca;
        logic          dv;
        logic [AW-1:0] da;
        logic          clr;
        logic          ewr, ecr, edm, eerr, eoea, eoeb;
        logic [AW-1:0] efill;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    function automatic vec_t mk(input int wv, wa, wd, cv, ca, dv, da, clr,
                                input int ewr, ecr, edm, eerr, eoea, eoeb, efill);
        vec_t v;
        v.wv = 1'(wv);  v.wa = 8'(wa);  v.wd = 8'(wd);
        v.cv = 1'(cv);  v.ca = 8'(ca);
        v.dv = 1'(dv);  v.da = 8'(da);  v.clr = 1'(clr);
        v.ewr = 1'(ewr); v.ecr = 1'(ecr); v.edm = 1'(edm);
        v.eerr = 1'(eerr); v.eoea = 1'(eoea); v.eoeb = 1'(eoeb);
        v.efill = 8'(efill);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic drive(input vec_t v);
        wr_valid = v.wv; wr_addr = v.wa; wr_data = {16{v.wd}};
        cr_valid = v.cv; cr_addr = v.ca;
        dm_valid = v.dv; dm_addr = v.da;
        clear    = v.clr;
    endtask

    task automatic idle();
        wr_valid = 0; cr_valid = 0; dm_valid = 0; clear = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        //          wv wa  wd    cv ca   dv da  clr ewr ecr     edm err oea oeb fill
        tbl[0]  = mk(1, 5, 'hA5, 0, 0,   0, 0,   0, 1, 0,       0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,    1, 5,   0, 0,   0, 0, 1,       0, 0, 0, 1, 1);
        tbl[2]  = mk(0, 0, 0,    1, 10,  0, 0,   0, 0, 0,       0, 0, 0, 0, 1);
        tbl[3]  = mk(1, 10,'h3C, 1, 10,  0, 0,   0, 1, int'(FWD),0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0,    1, 10,  0, 0,   0, 0, 1,       0, 0, 0, 1, 2);
        tbl[5]  = mk(1, 3, 'h33, 0, 0,   0, 0,   0, 1, 0,       0, 0, 0, 0, 2);
        tbl[6]  = mk(1, 4, 'h44, 0, 0,   0, 0,   0, 1, 0,       0, 0, 0, 0, 3);
        tbl[7]  = mk(0, 0, 0,    1, 3,   1, 4,   0, 0, 1,       1, 0, 1, 1, 4);
        tbl[8]  = mk(0, 0, 0,    0, 0,   1, 4,   0, 0, 0,       1, 0, 0, 1, 4);
        tbl[9]  = mk(0, 0, 0,    1, 3,   1, 3,   0, 0, 1,       0, 0, 0, 1, 4);
        tbl[10] = mk(0, 0, 0,    0, 0,   1, 3,   0, 0, 0,       1, 0, 0, 1, 4);
        tbl[11] = mk(0, 0, 0,    0, 0,   1, 144, 0, 0, 0,       0, 1, 0, 0, 4);
        tbl[12] = mk(1, 150,'h11,1, 200, 0, 0,   0, 0, 0,       0, 1, 0, 0, 4);
        tbl[13] = mk(1, 9, 'h99, 0, 0,   1, 9,   0, 1, 0,       0, 0, 0, 0, 4);
        tbl[14] = mk(1, 11,'hBB, 0, 0,   1, 9,   0, 1, 0,       1, 0, 0, 1, 5);
        tbl[15] = mk(0, 0, 0,    1, 3,   0, 0,   1, 0, 0,       0, 0, 0, 0, 6);
        tbl[16] = mk(0, 0, 0,    1, 3,   0, 0,   0, 0, 0,       0, 0, 0, 0, 0);

        RSTn = 0; idle(); wr_addr = 0; wr_data = '0; cr_addr = 0;
        wr_valid = 1; wr_addr = 5; dm_valid = 1; dm_addr = 200;
        repeat (2) @(posedge CK);
        #3;
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_dm_ready", 32'(dm_ready), 0);
        chk("rst_err_addr", 32'(err_addr), 0);
        chk("rst_we_n", 32'({WEAN, WEBN}), 3);
        chk("rst_oe", 32'({OEA, OEB}), 0);
        chk("rst_addr", 32'({A, B}), 0);
        chk("rst_dia_nz", 32'(DIA != '0), 0);
        chk("rst_fill", 32'(fill_cnt), 0);
        chk("rst_rvalid", 32'({cr_rvalid, dm_rvalid}), 0);
        idle();
        RSTn = 1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #2;
            chk($sformatf("r%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].ewr));
            chk($sformatf("r%0d_cr_ready", i), 32'(cr_ready), 32'(tbl[i].ecr));
            chk($sformatf("r%0d_dm_ready", i), 32'(dm_ready), 32'(tbl[i].edm));
            chk($sformatf("r%0d_err_addr", i), 32'(err_addr), 32'(tbl[i].eerr));
            chk($sformatf("r%0d_oea", i), 32'(OEA), 32'(tbl[i].eoea));
            chk($sformatf("r%0d_oeb", i), 32'(OEB), 32'(tbl[i].eoeb));
            chk($sformatf("r%0d_fill", i), 32'(fill_cnt), 32'(tbl[i].efill));
            tick();
        end

        // same-cycle write and compute read of one word
        idle();
        wr_valid = 1; wr_addr = 7; wr_data = {16{8'h77}};
        cr_valid = 1; cr_addr = 7;
        #2;
        chk("h1_wr_ready", 32'(wr_ready), 1);
        chk("h1_cr_ready", 32'(cr_ready), 32'(FWD));
        tick();
        wr_valid = 0;
        cr_valid = !FWD;
        #2;
        chk("h1_cr_next", 32'(cr_ready), 32'(!FWD));
        chk("h1_fwd_rvalid", 32'(cr_rvalid), 32'(FWD));
        chk("h1_fill", 32'(fill_cnt), 1);
        tick();
        idle();
        tick();

        // fill every word, rewrite one, then clear
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1; wr_addr = 8'(i); wr_data = {16{8'(i) ^ 8'h5A}};
            #2;
            chk($sformatf("fill_wr%0d", i), 32'(wr_ready), 1);
            tick();
        end
        wr_valid = 0;
        #2;
        chk("full_cnt", 32'(fill_cnt), 144);
        chk("full_flag", 32'(all_written), 1);
        tick();
        wr_valid = 1; wr_addr = 0; wr_data = {16{8'hD0}};
        tick();
        wr_valid = 0;
        #2;
        chk("rewrite_cnt", 32'(fill_cnt), 144);
        chk("rewrite_flag", 32'(all_written), 1);
        tick();
        cr_valid = 1; cr_addr = 0;
        #2;
        chk("pre_clr_cr_ready", 32'(cr_ready), 1);
        tick();
        clear = 1; wr_valid = 1; wr_addr = 1; wr_data = {16{8'hEE}};
        #2;
        chk("clr_cr_ready", 32'(cr_ready), 0);
        chk("clr_wr_ready", 32'(wr_ready), 0);
        chk("clr_prior_rvalid", 32'(cr_rvalid), 1);
        tick();
        clear = 0; wr_valid = 0;
        #2;
        chk("post_clr_cnt", 32'(fill_cnt), 0);
        chk("post_clr_flag", 32'(all_written), 0);
        chk("post_clr_cr_stall", 32'(cr_ready), 0);
        tick();

        // reset with a read in flight
        idle();
        wr_valid = 1; wr_addr = 1; wr_data = {16{8'h1E}};
        tick();
        wr_valid = 0; cr_valid = 1; cr_addr = 1;
        #2;
        chk("mid_rst_grant", 32'(cr_ready), 1);
        #4;
        RSTn = 0;
        tick();
        #2;
        chk("mid_rst_rvalid", 32'(cr_rvalid), 0);
        chk("mid_rst_fill", 32'(fill_cnt), 0);
        tick();
        cr_valid = 0;
        RSTn = 1;
        #2;
        chk("post_rst_rvalid", 32'(cr_rvalid), 0);
        tick();
        #2;
        chk("post_rst_rvalid2", 32'(cr_rvalid), 0);
        repeat (3) tick();

        chk("cr_q_drained", 32'(cr_q.size()), 0);
        chk("dm_q_drained", 32'(dm_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
